// File: rtl/harq_llr_combiner.sv
// harq_llr_combiner
//   HARQ soft-combining engine. One code block per request: the first
//   circular-buffer pass is written as sign-extended LLRs (FILL), later
//   passes are saturating-added onto the stored words (COMBINE). Two
//   ping-pong banks: o_bank is the bank being combined, and ~o_bank is
//   served on the readout port.
//
// Ports
//   i_core_clk, i_rx_rstn  clock, asynchronous active-low reset
//   i_rx_fsm_rstn          synchronous active-low abort (to IDLE, no o_done)
//   i_req                  start a block (sampled in IDLE only)
//   i_user_idx             user select; i_users_ncb holds Ncb per user
//   o_busy                 high outside IDLE
//   o_rdm_req              high in FILL/COMBINE, beats may be sent
//   i_rdm_valid/data/last  LLR beat input, LANES x LLR_W
//   o_done, o_err          1-cycle completion pulse, error flag with it
//   o_sat_cnt              saturated-LLR count for current/last block
//   o_bank                 bank being combined
//   i_rd_addr, o_rd_data   readout of bank ~o_bank, 1-cycle latency
module harq_llr_combiner #(
  parameter int unsigned LLR_W     = 6,
  parameter int unsigned ACC_W     = 10,
  parameter int unsigned LANES     = 16,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned NUM_USERS = 8,
  parameter int unsigned NCB_W     = 16
) (
  input  logic                       i_core_clk,
  input  logic                       i_rx_rstn,
  input  logic                       i_rx_fsm_rstn,
  input  logic                       i_req,
  input  logic [3:0]                 i_user_idx,
  input  logic [NUM_USERS*NCB_W-1:0] i_users_ncb,
  output logic                       o_busy,
  output logic                       o_rdm_req,
  input  logic                       i_rdm_valid,
  input  logic [LANES*LLR_W-1:0]     i_rdm_data,
  input  logic                       i_rdm_last,
  output logic                       o_done,
  output logic                       o_err,
  output logic [15:0]                o_sat_cnt,
  output logic                       o_bank,
  input  logic [ADDR_W-1:0]          i_rd_addr,
  output logic [LANES*ACC_W-1:0]     o_rd_data
);

  localparam int unsigned LANE_LG = $clog2(LANES);
  localparam int unsigned DEPTH   = 2**ADDR_W;
  localparam int unsigned WORD_W  = LANES*ACC_W;
  localparam int unsigned CNT_W   = $clog2(LANES+1);

  // Symmetric clip limits; the most negative code is never stored.
  localparam logic signed [ACC_W:0] SMAX = $signed({2'b00, {(ACC_W-1){1'b1}}});
  localparam logic signed [ACC_W:0] SMIN = -SMAX;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_COMBINE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WORD_W-1:0] mem [0:2*DEPTH-1];

  logic [NCB_W-1:0]  ncb_sel;
  logic [NCB_W:0]    nw_full;
  logic              nw_bad;
  logic [ADDR_W-1:0] nw_m1;
  logic [ADDR_W-1:0] addr;
  logic              err_q;
  logic              bank;
  logic [15:0]       sat_cnt;

  logic              accept, beat_ok, req_ok, wrap;

  logic              p_valid;
  logic              p_fill;
  logic [ADDR_W-1:0] p_addr;
  logic [LANES*LLR_W-1:0] p_llr;
  logic [WORD_W-1:0] rmw_q;
  logic              wr_en, fwd_hit;
  logic [WORD_W-1:0] wr_data;
  logic [CNT_W-1:0]  clip_cnt;
  logic [16:0]       sat_sum;
  logic [WORD_W-1:0] rd_q;

  // Ncb selection; out-of-range user index reads as Ncb=0.
  always_comb begin
    ncb_sel = '0;
    for (int unsigned u = 0; u < NUM_USERS; u++) begin
      if (i_user_idx == u[3:0]) ncb_sel = i_users_ncb[u*NCB_W +: NCB_W];
    end
  end

  assign nw_full = ({1'b0, ncb_sel} + (NCB_W+1)'(LANES-1)) >> LANE_LG;
  assign nw_bad  = (nw_full == '0) || (nw_full > (NCB_W+1)'(DEPTH));

  assign accept  = o_rdm_req && i_rdm_valid;
  assign beat_ok = accept && i_rx_fsm_rstn;
  assign req_ok  = (state == S_IDLE) && i_req && i_rx_fsm_rstn;
  assign wrap    = (addr == nw_m1);

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) state <= S_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b0;
    o_rdm_req = 1'b0;
    o_done    = 1'b0;
    o_err     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_req) state_nxt = nw_bad ? S_DRAIN : S_FILL;
      end
      S_FILL: begin
        o_busy    = 1'b1;
        o_rdm_req = 1'b1;
        if (accept) begin
          if (i_rdm_last) state_nxt = S_DRAIN;
          else if (wrap)  state_nxt = S_COMBINE;
        end
      end
      S_COMBINE: begin
        o_busy    = 1'b1;
        o_rdm_req = 1'b1;
        if (accept && i_rdm_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        o_busy    = 1'b1;
        o_done    = 1'b1;
        o_err     = err_q;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!i_rx_fsm_rstn) state_nxt = S_IDLE;
  end

  // Per-lane add/clip of the write stage; stored word is RAM q or the
  // forwarded previous write when the same word is being re-read.
  always_comb begin
    logic [LLR_W-1:0]        llr;
    logic [ACC_W-1:0]        st;
    logic signed [ACC_W:0]   llr_x;
    logic signed [ACC_W:0]   sum;
    logic [ACC_W-1:0]        lane;
    wr_data  = '0;
    clip_cnt = '0;
    llr      = '0;
    st       = '0;
    llr_x    = '0;
    sum      = '0;
    lane     = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      llr   = p_llr[k*LLR_W +: LLR_W];
      st    = rmw_q[k*ACC_W +: ACC_W];
      llr_x = $signed({{(ACC_W+1-LLR_W){llr[LLR_W-1]}}, llr});
      sum   = llr_x + $signed({st[ACC_W-1], st});
      if (p_fill) begin
        lane = llr_x[ACC_W-1:0];
      end else if (sum > SMAX) begin
        lane     = SMAX[ACC_W-1:0];
        clip_cnt = clip_cnt + 1'b1;
      end else if (sum < SMIN) begin
        lane     = SMIN[ACC_W-1:0];
        clip_cnt = clip_cnt + 1'b1;
      end else begin
        lane = sum[ACC_W-1:0];
      end
      wr_data[k*ACC_W +: ACC_W] = lane;
    end
  end

  assign wr_en   = p_valid && i_rx_fsm_rstn;
  assign fwd_hit = wr_en && (p_addr == addr);
  assign sat_sum = {1'b0, sat_cnt} + 17'(clip_cnt);

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      nw_m1   <= '0;
      addr    <= '0;
      err_q   <= 1'b0;
      bank    <= 1'b0;
      sat_cnt <= '0;
      p_valid <= 1'b0;
      rd_q    <= '0;
    end else begin
      rd_q    <= mem[{~bank, i_rd_addr}];
      p_valid <= beat_ok;
      if (req_ok) begin
        nw_m1 <= ADDR_W'(nw_full - 1'b1);
        addr  <= '0;
        err_q <= nw_bad;
      end else if (beat_ok) begin
        addr <= wrap ? '0 : addr + 1'b1;
      end
      if ((state == S_DRAIN) && i_rx_fsm_rstn) bank <= ~bank;
      if (req_ok)     sat_cnt <= '0;
      else if (wr_en) sat_cnt <= sat_sum[16] ? '1 : sat_sum[15:0];
    end
  end

  // Read-for-combine issued with the accepted beat; a write to the same
  // word landing on this edge is captured directly instead of stale q.
  always_ff @(posedge i_core_clk) begin
    p_fill <= (state == S_FILL);
    p_addr <= addr;
    p_llr  <= i_rdm_data;
    if (fwd_hit) rmw_q <= wr_data;
    else         rmw_q <= mem[{bank, addr}];
    if (wr_en) mem[{bank, p_addr}] <= wr_data;
  end

  assign o_sat_cnt = sat_cnt;
  assign o_bank    = bank;
  assign o_rd_data = rd_q;

endmodule

// File: tb/tb_harq_llr_combiner.sv
module tb_harq_llr_combiner;

  localparam int LLR_W     = 6;
  localparam int ACC_W     = 10;
  localparam int LANES     = 16;
  localparam int ADDR_W    = 11;
  localparam int NUM_USERS = 8;
  localparam int NCB_W     = 16;
  localparam int WORD_W    = LANES*ACC_W;
  localparam int LIM       = 2**(ACC_W-1)-1;

  logic                       clk;
  logic                       rx_rstn;
  logic                       fsm_rstn;
  logic                       req;
  logic [3:0]                 user_idx;
  logic [NUM_USERS*NCB_W-1:0] users_ncb;
  logic                       busy;
  logic                       rdm_req;
  logic                       rdm_valid;
  logic [LANES*LLR_W-1:0]     rdm_data;
  logic                       rdm_last;
  logic                       done;
  logic                       err;
  logic [15:0]                sat_cnt;
  logic                       bank;
  logic [ADDR_W-1:0]          rd_addr;
  logic [WORD_W-1:0]          rd_data;

  harq_llr_combiner #(
    .LLR_W(LLR_W), .ACC_W(ACC_W), .LANES(LANES), .ADDR_W(ADDR_W),
    .NUM_USERS(NUM_USERS), .NCB_W(NCB_W)
  ) dut (
    .i_core_clk(clk), .i_rx_rstn(rx_rstn), .i_rx_fsm_rstn(fsm_rstn),
    .i_req(req), .i_user_idx(user_idx), .i_users_ncb(users_ncb),
    .o_busy(busy), .o_rdm_req(rdm_req), .i_rdm_valid(rdm_valid),
    .i_rdm_data(rdm_data), .i_rdm_last(rdm_last), .o_done(done),
    .o_err(err), .o_sat_cnt(sat_cnt), .o_bank(bank),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int user; int ncb; int nbeats; int rnd; int val;
    int exp_err; int exp_sat; int exp_w0; int chk_w0;
  } rec_t;

  typedef struct {
    logic        err;
    logic [15:0] sat;
    logic        bnk;
  } done_t;

  done_t             sb_done[$];
  logic [WORD_W-1:0] sb_rd[$];
  rec_t              tbl[11];
  rec_t              post;
  int                tests = 0;
  int                fails = 0;
  logic              exp_bank;

  task automatic check(input string name, input logic [WORD_W-1:0] act,
                       input logic [WORD_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_block(input rec_t rc);
    int m[64][LANES];
    logic [LANES*LLR_W-1:0] beats[$];
    logic [LANES*LLR_W-1:0] d;
    logic [WORD_W-1:0] w;
    done_t e, got;
    int nw, a, v, s, sat_m, cnt, nchk;
    if (rc.user < NUM_USERS) users_ncb[rc.user*NCB_W +: NCB_W] = NCB_W'(rc.ncb);
    nw = (rc.user < NUM_USERS) ? (rc.ncb + LANES - 1) / LANES : 0;
    sat_m = 0;
    for (int b = 0; b < rc.nbeats; b++) begin
      a = b % nw;
      d = '0;
      for (int k = 0; k < LANES; k++) begin
        v = rc.rnd != 0 ? int'($urandom_range(16)) - 8 : rc.val;
        d[k*LLR_W +: LLR_W] = v[LLR_W-1:0];
        if (b < nw) m[a][k] = v;
        else begin
          s = m[a][k] + v;
          if (s > LIM)       begin s = LIM;  sat_m++; end
          else if (s < -LIM) begin s = -LIM; sat_m++; end
          m[a][k] = s;
        end
      end
      beats.push_back(d);
    end
    e.err = rc.exp_err[0];
    e.sat = 16'(sat_m);
    e.bnk = ~exp_bank;
    sb_done.push_back(e);

    @(negedge clk);
    user_idx = 4'(rc.user);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_req", WORD_W'(busy), WORD_W'(1));
    check("rdm_req_after_req", WORD_W'(rdm_req), WORD_W'(rc.exp_err == 0));
    for (int b = 0; b < rc.nbeats; b++) begin
      if (rc.rnd != 0 && b == 2) begin
        rdm_valid = 1'b0;
        @(negedge clk);
      end
      rdm_valid = 1'b1;
      rdm_data  = beats[b];
      rdm_last  = (b == rc.nbeats - 1);
      req       = (b == 1);
      user_idx  = 4'd9;
      if (b == 1) users_ncb = ~users_ncb;
      @(negedge clk);
    end
    rdm_valid = 1'b0;
    rdm_last  = 1'b0;
    req       = 1'b0;

    cnt = 0;
    while (done !== 1'b1 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    got = sb_done.pop_front();
    if (done !== 1'b1) begin
      check("done_timeout", WORD_W'(done), WORD_W'(1));
      exp_bank = bank;
    end else begin
      check("done_latency", WORD_W'(cnt + 1), WORD_W'(2));
      check("err", WORD_W'(err), WORD_W'(got.err));
      check("sat_cnt_model", WORD_W'(sat_cnt), WORD_W'(got.sat));
      check("sat_cnt_table", WORD_W'(sat_cnt), WORD_W'(rc.exp_sat));
      check("bank_toggle", WORD_W'(bank), WORD_W'(got.bnk));
      exp_bank = ~exp_bank;
      @(negedge clk);
      check("done_pulse_width", WORD_W'(done), WORD_W'(0));
    end

    nchk = (rc.exp_err != 0) ? 0 : ((nw < rc.nbeats) ? nw : rc.nbeats);
    for (int wa = 0; wa < nchk; wa++) begin
      w = '0;
      for (int k = 0; k < LANES; k++) begin
        s = m[wa][k];
        w[k*ACC_W +: ACC_W] = s[ACC_W-1:0];
      end
      sb_rd.push_back(w);
      rd_addr = ADDR_W'(wa);
      @(negedge clk);
      w = sb_rd.pop_front();
      check("readout_word", rd_data, w);
      if (wa == 0 && rc.chk_w0 != 0) begin
        w = '0;
        v = rc.exp_w0;
        for (int k = 0; k < LANES; k++) w[k*ACC_W +: ACC_W] = v[ACC_W-1:0];
        check("readout_w0_table", rd_data, w);
      end
    end
  endtask

  initial begin
    rx_rstn   = 1'b0;
    fsm_rstn  = 1'b1;
    req       = 1'b0;
    user_idx  = '0;
    users_ncb = '0;
    rdm_valid = 1'b0;
    rdm_data  = '0;
    rdm_last  = 1'b0;
    rd_addr   = '0;
    exp_bank  = 1'b0;

    tbl[0]  = '{0,    64,  4, 0,   3, 0,   0,    3, 1};
    tbl[1]  = '{1,    64,  8, 0,  31, 0,   0,   62, 1};
    tbl[2]  = '{2,    16, 20, 0,  31, 0,  64,  511, 1};
    tbl[3]  = '{3,    16, 32, 0, -32, 0, 272, -511, 1};
    tbl[4]  = '{9,     0,  0, 0,   0, 1,   0,    0, 0};
    tbl[5]  = '{4,     0,  0, 0,   0, 1,   0,    0, 0};
    tbl[6]  = '{5, 32769,  0, 0,   0, 1,   0,    0, 0};
    tbl[7]  = '{6, 32768,  1, 0,  -7, 0,   0,   -7, 1};
    tbl[8]  = '{7,    32,  5, 1,   0, 0,   0,    0, 0};
    tbl[9]  = '{0,    40,  7, 1,   0, 0,   0,    0, 0};
    tbl[10] = '{1,    17,  3, 0,  31, 0,   0,   62, 1};
    post    = '{2,   128,  8, 0,   5, 0,   0,    5, 1};

    repeat (3) @(negedge clk);
    check("rst_busy",    WORD_W'(busy),    WORD_W'(0));
    check("rst_rdm_req", WORD_W'(rdm_req), WORD_W'(0));
    check("rst_done",    WORD_W'(done),    WORD_W'(0));
    check("rst_err",     WORD_W'(err),     WORD_W'(0));
    check("rst_sat",     WORD_W'(sat_cnt), WORD_W'(0));
    check("rst_bank",    WORD_W'(bank),    WORD_W'(0));
    check("rst_rd_data", rd_data,          WORD_W'(0));
    rx_rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_block(tbl[i]);

    // abort after beat 3 of an 8-beat block
    users_ncb[2*NCB_W +: NCB_W] = 16'd128;
    @(negedge clk);
    user_idx = 4'd2;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rdm_valid = 1'b1;
      rdm_data  = '0;
      rdm_last  = 1'b0;
      @(negedge clk);
    end
    rdm_valid = 1'b0;
    fsm_rstn  = 1'b0;
    @(negedge clk);
    fsm_rstn = 1'b1;
    check("abort_busy",    WORD_W'(busy),    WORD_W'(0));
    check("abort_rdm_req", WORD_W'(rdm_req), WORD_W'(0));
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
        if (done === 1'b1) seen = 1'b1;
        @(negedge clk);
      end
      check("abort_no_done", WORD_W'(seen), WORD_W'(0));
    end
    check("abort_bank", WORD_W'(bank), WORD_W'(exp_bank));
    run_block(post);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
